// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the MEM-stage data-cache access controller: word type,
// access kinds, FSM states and the launch-time op decode.
package mem_access_ctrl_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [2:0] {
        mem_none, mem_ldw, mem_ldb, mem_stw, mem_stb, mem_ldi, mem_sti
    } lc3b_mem_op;

    typedef enum logic [1:0] {
        ms_idle, ms_req1, ms_req2, ms_done
    } lc3b_mem_state;

    // Indirect ops override the plain read/write bits, so test them first.
    function automatic lc3b_mem_op decode_mem_op(input logic dcacheR, input logic dcacheW,
                                                 input logic ldb_op, input logic stb_op,
                                                 input logic ldi_op, input logic sti_op);
        if (sti_op)       return mem_sti;
        else if (ldi_op)  return mem_ldi;
        else if (stb_op)  return mem_stb;
        else if (ldb_op)  return mem_ldb;
        else if (dcacheW) return mem_stw;
        else if (dcacheR) return mem_ldw;
        else              return mem_none;
    endfunction

    // The first access of every op except plain stores is a read.
    function automatic logic first_is_read(input lc3b_mem_op op);
        return (op == mem_ldw) || (op == mem_ldb) || (op == mem_ldi) || (op == mem_sti);
    endfunction

endpackage

// File: rtl/mem_byte_align.sv
// Byte-lane steering for data-cache accesses: byte enables and replicated store
// data for STB, lane select plus sign extension for LDB; word ops pass through.
module mem_byte_align
    import mem_access_ctrl_pkg::*;
(
    input  lc3b_mem_op  op,
    input  logic        addr_lsb,
    input  lc3b_word    wdata,
    input  lc3b_word    rdata,
    output logic [1:0]  byte_enable,
    output lc3b_word    wdata_aligned,
    output lc3b_word    rdata_aligned
);

    logic [7:0] rbyte;

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        byte_enable   = 2'b11;
        wdata_aligned = wdata;
        rdata_aligned = rdata;
        rbyte         = addr_lsb ? rdata[15:8] : rdata[7:0];
        if (op == mem_stb) begin
            byte_enable   = addr_lsb ? 2'b10 : 2'b01;
            wdata_aligned = {wdata[7:0], wdata[7:0]};
        end
        if (op == mem_ldb)
            rdata_aligned = {{8{rbyte[7]}}, rbyte};
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-cache sequencer: launches single and indirect (two-access)
// operations, stalls the pipeline until complete and pulses done once.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        dcache_enable,
    input  logic        dcacheR,
    input  logic        dcacheW,
    input  logic        ldb_op,
    input  logic        stb_op,
    input  logic        ldi_op,
    input  logic        sti_op,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    input  logic        dmem_resp,
    input  logic [15:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] rdata_out,
    output logic        stall,
    output logic        done
);

    lc3b_mem_state state, next_state;
    lc3b_mem_op    launch_op, op_q;
    lc3b_word      addr_q, wdata_q, rdata_q;
    lc3b_word      wdata_aligned, rdata_aligned;
    logic [1:0]    be_aligned;
    logic          launch, is_indirect, is_load;

    assign launch_op   = decode_mem_op(dcacheR, dcacheW, ldb_op, stb_op, ldi_op, sti_op);
    // Gated by reset so the combinational launch stall also drops while reset is held.
    assign launch      = (state == ms_idle) && valid_in && dcache_enable &&
                         (launch_op != mem_none) && !reset;
    assign is_indirect = (op_q == mem_ldi) || (op_q == mem_sti);
    assign is_load     = (op_q == mem_ldw) || (op_q == mem_ldb);

    mem_byte_align u_align (
        .op            (op_q),
        .addr_lsb      (addr_q[0]),
        .wdata         (wdata_q),
        .rdata         (dmem_rdata),
        .byte_enable   (be_aligned),
        .wdata_aligned (wdata_aligned),
        .rdata_aligned (rdata_aligned)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ms_idle;
        else       state <= next_state;
    end

    // Once the pointer arrives, addr_q is reused to hold it for the second access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= mem_none;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (launch) begin
                op_q    <= launch_op;
                addr_q  <= addr_in;
                wdata_q <= wdata_in;
            end
            if (state == ms_req1 && dmem_resp) begin
                if (is_indirect)  addr_q  <= dmem_rdata;
                else if (is_load) rdata_q <= rdata_aligned;
            end
            if (state == ms_req2 && dmem_resp && op_q == mem_ldi)
                rdata_q <= rdata_aligned;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ms_idle: if (launch)    next_state = ms_req1;
            ms_req1: if (dmem_resp) next_state = is_indirect ? ms_req2 : ms_done;
            ms_req2: if (dmem_resp) next_state = ms_done;
            ms_done:                next_state = ms_idle;
            default:                next_state = ms_idle;
        endcase
    end

    logic req_read, req_write;

    always_comb begin
        req_read         = 1'b0;
        req_write        = 1'b0;
        stall            = 1'b0;
        done             = 1'b0;
        dmem_address     = '0;
        dmem_wdata       = '0;
        dmem_byte_enable = 2'b00;
        unique case (state)
            ms_idle: stall = launch;
            ms_req1: begin
                stall     = 1'b1;
                req_read  = first_is_read(op_q);
                req_write = !first_is_read(op_q);
            end
            ms_req2: begin
                stall     = 1'b1;
                req_read  = (op_q == mem_ldi);
                req_write = (op_q == mem_sti);
            end
            ms_done: done = 1'b1;
            default: ;
        endcase
        if (req_read || req_write) begin
            dmem_address     = addr_q;
            dmem_byte_enable = be_aligned;
        end
        if (req_write) dmem_wdata = wdata_aligned;
    end

    assign dmem_read  = req_read;
    assign dmem_write = req_write;
    assign rdata_out  = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: word/byte loads and stores, indirect ops,
// no-op launch suppression and reset abandoning an access mid-flight.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, dcache_enable, dcacheR, dcacheW, ldb_op, stb_op, ldi_op, sti_op;
    logic [15:0] addr_in, wdata_in, dmem_rdata;
    logic        dmem_resp;
    logic        dmem_read, dmem_write, stall, done;
    logic [15:0] dmem_address, dmem_wdata, rdata_out;
    logic [1:0]  dmem_byte_enable;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .valid_in         (valid_in),
        .dcache_enable    (dcache_enable),
        .dcacheR          (dcacheR),
        .dcacheW          (dcacheW),
        .ldb_op           (ldb_op),
        .stb_op           (stb_op),
        .ldi_op           (ldi_op),
        .sti_op           (sti_op),
        .addr_in          (addr_in),
        .wdata_in         (wdata_in),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .rdata_out        (rdata_out),
        .stall            (stall),
        .done             (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Packed view {read, write, stall, done, byte_enable}.
    function automatic logic [5:0] ctl();
        return {dmem_read, dmem_write, stall, done, dmem_byte_enable};
    endfunction

    // bits = {dcacheR, dcacheW, ldb_op, stb_op, ldi_op, sti_op}
    task automatic drive(input logic v, input logic [5:0] bits, input logic [15:0] a, input logic [15:0] wd);
        valid_in      = v;
        dcache_enable = v;
        {dcacheR, dcacheW, ldb_op, stb_op, ldi_op, sti_op} = bits;
        addr_in  = a;
        wdata_in = wd;
    endtask

    // Launch, one REQ1 cycle with immediate resp, then DONE.
    task automatic single_access(input string nm, input logic [5:0] bits, input logic [15:0] a,
                                 input logic [15:0] wd, input logic [15:0] rd, input logic [5:0] exp_ctl,
                                 input logic [15:0] exp_wd, input logic [15:0] exp_out);
        @(negedge clk);
        drive(1'b1, bits, a, wd);
        dmem_resp = 1'b0;
        #1;
        if (ctl() !== 6'b001000) begin $display("FAIL %s launch ctl got %b want %b", nm, ctl(), 6'b001000); n_bad++; end
        n_cmp++;
        @(negedge clk);
        dmem_resp  = 1'b1;
        dmem_rdata = rd;
        #1;
        if (ctl() !== exp_ctl) begin $display("FAIL %s req ctl got %b want %b", nm, ctl(), exp_ctl); n_bad++; end
        n_cmp++;
        if (dmem_address !== a) begin $display("FAIL %s req addr got %h want %h", nm, dmem_address, a); n_bad++; end
        n_cmp++;
        if (dmem_wdata !== exp_wd) begin $display("FAIL %s req wdata got %h want %h", nm, dmem_wdata, exp_wd); n_bad++; end
        n_cmp++;
        @(negedge clk);
        dmem_resp  = 1'b0;
        dmem_rdata = 16'h0;
        #1;
        if (ctl() !== 6'b000100) begin $display("FAIL %s done ctl got %b want %b", nm, ctl(), 6'b000100); n_bad++; end
        n_cmp++;
        if (rdata_out !== exp_out) begin $display("FAIL %s rdata_out got %h want %h", nm, rdata_out, exp_out); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        dmem_resp  = 1'b0;
        dmem_rdata = 16'h0;
        drive(1'b1, 6'b100000, 16'h3000, 16'h1111);
        @(negedge clk);
        #1;
        if (ctl() !== 6'b000000) begin $display("FAIL reset ctl got %b want %b", ctl(), 6'b000000); n_bad++; end
        n_cmp++;
        if ({dmem_address, dmem_wdata, rdata_out} !== 48'h0) begin
            $display("FAIL reset data got %h/%h/%h want 0", dmem_address, dmem_wdata, rdata_out); n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 6'b000000, 16'h0, 16'h0);
    endtask

    task automatic test_ldw();
        @(negedge clk);
        drive(1'b1, 6'b100000, 16'h3000, 16'h0);
        #1;
        if (ctl() !== 6'b001000) begin $display("FAIL ldw launch ctl got %b want %b", ctl(), 6'b001000); n_bad++; end
        n_cmp++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dmem_resp  = (i == 2);
            dmem_rdata = (i == 2) ? 16'hBEEF : 16'h0;
            #1;
            if (ctl() !== 6'b101011) begin $display("FAIL ldw req%0d ctl got %b want %b", i, ctl(), 6'b101011); n_bad++; end
            n_cmp++;
            if (dmem_address !== 16'h3000) begin $display("FAIL ldw req%0d addr got %h want 3000", i, dmem_address); n_bad++; end
            n_cmp++;
        end
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        if (ctl() !== 6'b000100) begin $display("FAIL ldw done ctl got %b want %b", ctl(), 6'b000100); n_bad++; end
        n_cmp++;
        if (rdata_out !== 16'hBEEF) begin $display("FAIL ldw rdata_out got %h want beef", rdata_out); n_bad++; end
        n_cmp++;
        @(negedge clk);
        drive(1'b0, 6'b000000, 16'h0, 16'h0);
        #1;
        if (ctl() !== 6'b000000) begin $display("FAIL ldw idle ctl got %b want %b", ctl(), 6'b000000); n_bad++; end
        n_cmp++;
        if (rdata_out !== 16'hBEEF) begin $display("FAIL ldw hold rdata_out got %h want beef", rdata_out); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_ldb();
        single_access("ldb_hi", 6'b101000, 16'h3001, 16'h0, 16'h80FF, 6'b101011, 16'h0, 16'hFF80);
        single_access("ldb_lo", 6'b101000, 16'h3000, 16'h0, 16'h7F80, 6'b101011, 16'h0, 16'hFF80);
        single_access("ldb_pos", 6'b101000, 16'h3001, 16'h0, 16'h7F00, 6'b101011, 16'h0, 16'h007F);
    endtask

    task automatic test_stores();
        single_access("stb_hi", 6'b010100, 16'h4001, 16'h00A5, 16'h0, 6'b011010, 16'hA5A5, 16'h007F);
        single_access("stb_lo", 6'b010100, 16'h4000, 16'h12A5, 16'h0, 6'b011001, 16'hA5A5, 16'h007F);
        single_access("stw", 6'b010000, 16'h4002, 16'h1357, 16'h0, 6'b011011, 16'h1357, 16'h007F);
    endtask

    task automatic test_ldi();
        @(negedge clk);
        drive(1'b1, 6'b100010, 16'h5000, 16'h0);
        dmem_resp = 1'b0;
        #1;
        if (ctl() !== 6'b001000) begin $display("FAIL ldi launch ctl got %b want %b", ctl(), 6'b001000); n_bad++; end
        n_cmp++;
        @(negedge clk);
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h6000;
        #1;
        if (ctl() !== 6'b101011 || dmem_address !== 16'h5000) begin
            $display("FAIL ldi req1 ctl/addr got %b/%h want %b/5000", ctl(), dmem_address, 6'b101011); n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        dmem_rdata = 16'h1234;
        #1;
        if (ctl() !== 6'b101011 || dmem_address !== 16'h6000) begin
            $display("FAIL ldi req2 ctl/addr got %b/%h want %b/6000", ctl(), dmem_address, 6'b101011); n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        dmem_resp  = 1'b0;
        dmem_rdata = 16'h0;
        #1;
        if (ctl() !== 6'b000100) begin $display("FAIL ldi done ctl got %b want %b", ctl(), 6'b000100); n_bad++; end
        n_cmp++;
        if (rdata_out !== 16'h1234) begin $display("FAIL ldi rdata_out got %h want 1234", rdata_out); n_bad++; end
        n_cmp++;
        @(negedge clk);
        drive(1'b0, 6'b000000, 16'h0, 16'h0);
        #1;
        if (done !== 1'b0) begin $display("FAIL ldi single done got %b want 0", done); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_sti();
        @(negedge clk);
        drive(1'b1, 6'b110011, 16'h5000, 16'h00C3);
        dmem_resp = 1'b0;
        #1;
        if (ctl() !== 6'b001000) begin $display("FAIL sti launch ctl got %b want %b", ctl(), 6'b001000); n_bad++; end
        n_cmp++;
        @(negedge clk);
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h7000;
        #1;
        if (ctl() !== 6'b101011 || dmem_address !== 16'h5000 || dmem_wdata !== 16'h0) begin
            $display("FAIL sti req1 got %b/%h/%h want %b/5000/0000", ctl(), dmem_address, dmem_wdata, 6'b101011); n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        dmem_rdata = 16'hDEAD;
        #1;
        if (ctl() !== 6'b011011 || dmem_address !== 16'h7000 || dmem_wdata !== 16'h00C3) begin
            $display("FAIL sti req2 got %b/%h/%h want %b/7000/00c3", ctl(), dmem_address, dmem_wdata, 6'b011011); n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        if (ctl() !== 6'b000100) begin $display("FAIL sti done ctl got %b want %b", ctl(), 6'b000100); n_bad++; end
        n_cmp++;
        if (rdata_out !== 16'h1234) begin $display("FAIL sti rdata_out got %h want 1234", rdata_out); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_no_launch();
        @(negedge clk);
        drive(1'b1, 6'b000000, 16'h3000, 16'h0);
        #1;
        if (ctl() !== 6'b000000) begin $display("FAIL none_op ctl got %b want %b", ctl(), 6'b000000); n_bad++; end
        n_cmp++;
        @(negedge clk);
        dcacheR       = 1'b1;
        dcache_enable = 1'b0;
        #1;
        if (ctl() !== 6'b000000) begin $display("FAIL no_enable ctl got %b want %b", ctl(), 6'b000000); n_bad++; end
        n_cmp++;
        @(negedge clk);
        #1;
        if (ctl() !== 6'b000000) begin $display("FAIL no_launch_after ctl got %b want %b", ctl(), 6'b000000); n_bad++; end
        n_cmp++;
        drive(1'b0, 6'b000000, 16'h0, 16'h0);
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        drive(1'b1, 6'b100010, 16'h5000, 16'h0);
        dmem_resp = 1'b0;
        @(negedge clk);
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h6000;
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        if (ctl() !== 6'b101011 || dmem_address !== 16'h6000) begin
            $display("FAIL rst_mid req2 got %b/%h want %b/6000", ctl(), dmem_address, 6'b101011); n_bad++;
        end
        n_cmp++;
        reset = 1'b1;
        #1;
        if (ctl() !== 6'b000000) begin $display("FAIL rst_mid ctl got %b want %b", ctl(), 6'b000000); n_bad++; end
        n_cmp++;
        if (rdata_out !== 16'h0 || dmem_address !== 16'h0) begin
            $display("FAIL rst_mid data got %h/%h want 0000/0000", rdata_out, dmem_address); n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 6'b000000, 16'h0, 16'h0);
        #1;
        if (ctl() !== 6'b000000) begin $display("FAIL rst_mid release ctl got %b want %b", ctl(), 6'b000000); n_bad++; end
        n_cmp++;
        single_access("ldw_after_rst", 6'b100000, 16'h2000, 16'h0, 16'h5555, 6'b101011, 16'h0, 16'h5555);
    endtask

    initial begin
        test_reset();
        test_ldw();
        test_ldb();
        test_stores();
        test_ldi();
        test_sti();
        test_no_launch();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage responder for the data-cache control bits produced by the decode control word (dcache_enable, dcacheR, dcacheW, ldb_op, stb_op, ldi_op, sti_op).
- Sequences single accesses and the two-access indirect ops (LDI: read then read; STI: read then write) onto the data-cache interface.
- Performs byte-lane alignment and stalls the pipeline until the access completes.

Parameters:
- none; widths are fixed by lc3b_word (16 bits)

Ports:
- clk            in   1   clock; all state updates on rising edge
- reset          in   1   asynchronous, active-high; clears all state immediately
- valid_in       in   1   MEM stage holds a valid instruction
- dcache_enable  in   1   control word: instruction uses the data cache
- dcacheR        in   1   control word: read
- dcacheW        in   1   control word: write
- ldb_op         in   1   control word: byte load
- stb_op         in   1   control word: byte store
- ldi_op         in   1   control word: indirect (first access is a pointer read)
- sti_op         in   1   control word: indirect store (overrides ldi_op and dcacheR)
- addr_in        in   16  effective address from MEM stage
- wdata_in       in   16  store data (storemux output)
- dmem_resp      in   1   cache completes the current access this cycle
- dmem_rdata     in   16  cache read data, valid when dmem_resp=1
- dmem_read      out  1   read request
- dmem_write     out  1   write request
- dmem_address   out  16  request address
- dmem_wdata     out  16  request write data
- dmem_byte_enable out 2  byte-lane mask
- rdata_out      out  16  final load data (aligned/extended), held until next load
- stall          out  1   freeze IF..MEM pipeline registers
- done           out  1   one-cycle pulse when the instruction's memory work is complete

Behaviour:
- Reset: state=IDLE; every output is 0, including rdata_out; all latches are cleared. Reset mid-access abandons the access and drops the request the same cycle (async).
- Op decode at launch, priority top-down:
  - sti_op -> STI
  - ldi_op -> LDI
  - stb_op -> STB
  - ldb_op -> LDB
  - dcacheW -> STW
  - dcacheR -> LDW
  - otherwise NONE
- Launch condition: IDLE & valid_in & dcache_enable & op!=NONE.
- Launch actions: latch op, addr_in and wdata_in, then go to REQ1. stall=1 combinationally in the launch cycle. If op=NONE there is no launch and stall=0.
- States: IDLE, REQ1, REQ2, DONE.
  - REQ1, LDW/LDB/LDI/STI: dmem_read=1 at the latched address.
  - REQ1, STW/STB: dmem_write=1 at the latched address.
  - REQ1 with no resp: hold; request outputs are stable every cycle until dmem_resp.
  - REQ1 with resp, LDI/STI: latch dmem_rdata as the pointer, go to REQ2.
  - REQ1 with resp, loads: latch aligned data into rdata_out, go to DONE.
  - REQ1 with resp, stores: go to DONE.
  - REQ2: address = pointer. LDI asserts dmem_read; STI asserts dmem_write with the latched store data. On resp, the LDI result loads rdata_out. Then go to DONE.
  - DONE: done=1, stall=0, no request, unconditionally go to IDLE. The same instruction is still presented on valid_in during DONE and must not relaunch.
- stall=1 in REQ1, REQ2, and in the launch cycle; 0 otherwise.
- Minimum latency with same-cycle-next resp: launch, REQ1, DONE (3 cycles) for single ops; 4 cycles for indirect ops.
- Byte lanes:
  - Word ops (including the pointer read): byte_enable=2'b11, address passed unchanged.
  - STB: byte_enable = addr[0] ? 2'b10 : 2'b01; wdata = {wdata[7:0], wdata[7:0]}.
  - LDB: byte = addr[0] ? rdata[15:8] : rdata[7:0]; rdata_out = sign-extend(byte).
- dmem_wdata=0 on reads. dmem_resp is ignored in IDLE and DONE.
- dmem_read and dmem_write are never both 1.

Decomposition:
- lc3b_types additions:
  - enum lc3b_mem_op {mem_none, mem_ldw, mem_ldb, mem_stw, mem_stb, mem_ldi, mem_sti}
  - enum lc3b_mem_state {ms_idle, ms_req1, ms_req2, ms_done}
- One combinational sub-module, mem_byte_align: given op, addr[0], wdata and rdata, it produces byte_enable, aligned write data and extended read data.
- The FSM and latches stay in mem_access_ctrl.

Test Plan:
- LDW at x3000, resp after 2 wait cycles with rdata xBEEF:
  - dmem_read=1, addr x3000, be 2'b11 for 3 cycles, stall=1.
  - Then a DONE pulse with rdata_out=xBEEF, then IDLE with no relaunch.
- LDB at x3001, rdata x80FF -> rdata_out=xFF80; LDB at x3000, rdata x7F80 -> rdata_out=xFF80.
- STB at x4001, wdata x00A5 -> dmem_write=1, be 2'b10, wdata xA5A5; STB at x4000 -> be 2'b01.
- LDI at x5000 (resp x6000), then second access (resp x1234):
  - First read at x5000; second read at x6000.
  - rdata_out=x1234, done once.
  - Total 4 cycles with immediate resp.
- STI (sti_op=ldi_op=dcacheR=dcacheW=1) at x5000, wdata x00C3, pointer x7000:
  - First access is a read at x5000.
  - Second access is a write at x7000 with x00C3, be 2'b11.
- Reset asserted in REQ2 of an LDI:
  - Same-cycle dmem_read=0, stall=0, state IDLE, rdata_out=0.
  - After release, a new LDW launches normally.
